// File: rtl/ram_rep_pkg.sv
// ram_rep_pkg: shared definitions for the replicated N-read / 1-write RAM.
//   state_t        : controller states (INIT clears memory, READY serves traffic)
//   DEF_*          : default parameter values used by ram_nr1w_rep
//   addr_hit()     : address-equality helper used by the write-first bypass
package ram_rep_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_NREAD  = 32;
    localparam int DEF_BYPASS = 1;

    // True when a read and an accepted write target the same word.
    function automatic logic addr_hit(input logic rd_en, input logic wr_acc,
                                      input logic [63:0] rd_addr,
                                      input logic [63:0] wr_addr);
        return rd_en & wr_acc & (rd_addr == wr_addr);
    endfunction

endpackage

// File: rtl/ram_1r1w_bank.sv
// ram_1r1w_bank: one replica of the memory array.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (read register only; array has none)
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata holds when low
//   raddr : read address
//   rdata : registered read data (old contents on a same-cycle write collision)
module ram_1r1w_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Array kept reset-free so it maps onto block RAM; clearing is done by
    // the controller's sweep.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ram_nr1w_rep.sv
// ram_nr1w_rep: NREAD-read / 1-write RAM built from NREAD replicated 1R1W banks.
// Every write is broadcast to all banks; each read port owns one bank.
// After reset a controller sweeps zeros through every address (INIT), then
// accepts traffic (READY).
//   clk, rst   : clock, synchronous active-high reset
//   w_enb      : write request, accepted when w_rdy is high
//   w_addr     : write address
//   w_din      : write data
//   w_rdy      : high in READY
//   r_en       : per-port read enable (NREAD bits)
//   r_addr     : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   r_dout     : packed read data, port i at [i*DATA_W +: DATA_W], 1-cycle latency
//   r_vld      : per-port read-data valid
//   init_done  : high once the clear sweep has completed
module ram_nr1w_rep
    import ram_rep_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREAD  = DEF_NREAD,
    parameter int BYPASS = DEF_BYPASS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_enb,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [DATA_W-1:0]        w_din,
    output logic                     w_rdy,
    input  logic [NREAD-1:0]         r_en,
    input  logic [NREAD*ADDR_W-1:0]  r_addr,
    output logic [NREAD*DATA_W-1:0]  r_dout,
    output logic [NREAD-1:0]         r_vld,
    output logic                     init_done
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] init_cnt, init_cnt_nxt;
    logic              ready;
    logic              w_acc;
    logic              bank_we;
    logic [ADDR_W-1:0] bank_waddr;
    logic [DATA_W-1:0] bank_wdata;

    assign ready     = (state == READY);
    assign w_rdy     = ready;
    assign init_done = ready;

    // Writes presented in the reset cycle are dropped; the sweep that follows
    // would erase them anyway.
    assign w_acc = w_enb & ready & ~rst;

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // The counter parks at the last address instead of wrapping, so the
    // final clear write and the move to READY happen on the same edge.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        case (state)
            INIT: begin
                if (init_cnt == '1) state_nxt    = READY;
                else                init_cnt_nxt = init_cnt + 1'b1;
            end
            READY: begin
                state_nxt = READY;
            end
            default: state_nxt = INIT;
        endcase
    end

    // ---------------- shared write path ----------------
    always_comb begin
        bank_we    = 1'b0;
        bank_waddr = w_addr;
        bank_wdata = w_din;
        if (!rst) begin
            if (state == INIT) begin
                bank_we    = 1'b1;
                bank_waddr = init_cnt;
                bank_wdata = '0;
            end else begin
                bank_we = w_enb;
            end
        end
    end

    // ---------------- read ports ----------------
    for (genvar i = 0; i < NREAD; i++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] bank_q;
        logic              hit;
        logic              byp_q;
        logic [DATA_W-1:0] byp_d;
        logic              vld_q;

        assign addr = r_addr[i*ADDR_W +: ADDR_W];
        assign hit  = (BYPASS != 0) &&
                      addr_hit(r_en[i], w_acc, 64'(addr), 64'(w_addr));

        ram_1r1w_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (bank_we),
            .waddr (bank_waddr),
            .wdata (bank_wdata),
            .re    (r_en[i]),
            .raddr (addr),
            .rdata (bank_q)
        );

        // The bank returns old data on a collision; the select and captured
        // write data only change on an enabled read so an idle port keeps
        // showing its last result.
        always_ff @(posedge clk) begin
            if (rst) begin
                byp_q <= 1'b0;
                byp_d <= '0;
                vld_q <= 1'b0;
            end else begin
                vld_q <= r_en[i] & ready;
                if (r_en[i]) begin
                    byp_q <= hit;
                    if (hit) byp_d <= w_din;
                end
            end
        end

        assign r_dout[i*DATA_W +: DATA_W] = byp_q ? byp_d : bank_q;
        assign r_vld[i]                   = vld_q;
    end

endmodule

// File: tb/tb_ram_nr1w_rep.sv
module tb_ram_nr1w_rep;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 32;
    localparam int DEPTH = 2**AW;

    logic              clk;
    logic              rst;
    logic              w_enb;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_din;
    logic [NR-1:0]     r_en;
    logic [NR*AW-1:0]  r_addr;

    logic              w_rdy_b, w_rdy_o;
    logic [NR*DW-1:0]  r_dout_b, r_dout_o;
    logic [NR-1:0]     r_vld_b, r_vld_o;
    logic              done_b, done_o;

    int checks = 0;
    int errors = 0;

    ram_nr1w_rep #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst), .w_enb(w_enb), .w_addr(w_addr), .w_din(w_din),
        .w_rdy(w_rdy_b), .r_en(r_en), .r_addr(r_addr), .r_dout(r_dout_b),
        .r_vld(r_vld_b), .init_done(done_b)
    );

    ram_nr1w_rep #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .BYPASS(0)) dut_old (
        .clk(clk), .rst(rst), .w_enb(w_enb), .w_addr(w_addr), .w_din(w_din),
        .w_rdy(w_rdy_o), .r_en(r_en), .r_addr(r_addr), .r_dout(r_dout_o),
        .r_vld(r_vld_o), .init_done(done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic all_ports(input logic [AW-1:0] base, input logic step);
        for (int i = 0; i < NR; i++) r_addr[i*AW +: AW] = base + (step ? AW'(i) : AW'(0));
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            r_en = '1;
            all_ports(AW'(a), 1'b1);
            tick();
            for (int i = 0; i < NR; i++) begin
                chk({tag, "_byp"}, r_dout_b[i*DW +: DW], 32'h0);
                chk({tag, "_old"}, r_dout_o[i*DW +: DW], 32'h0);
            end
            chk({tag, "_vld"}, r_vld_b, '1);
        end
        r_en = '0;
    endtask

    initial begin
        rst = 1'b1; w_enb = 1'b0; w_addr = '0; w_din = '0; r_en = '0; r_addr = '0;

        // reset edge
        tick();
        chk("rst_done", 32'(done_b), 32'h0);
        chk("rst_wrdy", 32'(w_rdy_b), 32'h0);
        chk("rst_vld", r_vld_b, 32'h0);
        chk("rst_dout0", r_dout_b[0 +: DW], 32'h0);
        chk("rst_dout31_old", r_dout_o[31*DW +: DW], 32'h0);

        // clear sweep; write to 2 and reads during INIT must have no effect
        rst = 1'b0;
        w_enb = 1'b1; w_addr = 4'd2; w_din = 32'hAAAA5555;
        r_en = '1; all_ports('0, 1'b0);
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            chk("init_done", 32'(done_b), (k == DEPTH) ? 32'h1 : 32'h0);
            chk("init_done_old", 32'(done_o), (k == DEPTH) ? 32'h1 : 32'h0);
            chk("init_vld", r_vld_b, 32'h0);
        end
        w_enb = 1'b0; r_en = '0;
        chk("ready_wrdy", 32'(w_rdy_b), 32'h1);

        read_all_zero("clear");

        // broadcast write, all ports read same word
        w_enb = 1'b1; w_addr = 4'h5; w_din = 32'hDEADBEEF;
        tick();
        w_enb = 1'b0;
        r_en = '1; all_ports(4'h5, 1'b0);
        tick();
        r_en = '0;
        for (int i = 0; i < NR; i++) chk("bcast", r_dout_b[i*DW +: DW], 32'hDEADBEEF);
        chk("bcast_vld", r_vld_b, '1);

        // same-cycle read/write collision on port 3
        w_enb = 1'b1; w_addr = 4'h7; w_din = 32'h11111111;
        tick();
        w_din = 32'h22222222;
        r_en = 32'h8; r_addr[3*AW +: AW] = 4'h7;
        tick();
        w_enb = 1'b0; r_en = '0;
        chk("coll_byp", r_dout_b[3*DW +: DW], 32'h22222222);
        chk("coll_old", r_dout_o[3*DW +: DW], 32'h11111111);
        chk("coll_vld", r_vld_b, 32'h8);
        chk("coll_hold4", r_dout_b[4*DW +: DW], 32'hDEADBEEF);
        r_en = 32'h8;
        tick();
        r_en = '0;
        chk("after_coll_old", r_dout_o[3*DW +: DW], 32'h22222222);

        // preload a*0x01010101, then distinct per-port reads with port 5 idle
        for (int a = 0; a < DEPTH; a++) begin
            w_enb = 1'b1; w_addr = AW'(a); w_din = 32'(a) * 32'h01010101;
            tick();
        end
        w_enb = 1'b0;
        r_en = ~(32'h1 << 5); all_ports('0, 1'b1);
        tick();
        r_en = '0;
        for (int i = 0; i < NR; i++) begin
            if (i != 5) chk("distinct", r_dout_b[i*DW +: DW], 32'(i % DEPTH) * 32'h01010101);
        end
        chk("hold5_byp", r_dout_b[5*DW +: DW], 32'hDEADBEEF);
        chk("hold5_old", r_dout_o[5*DW +: DW], 32'hDEADBEEF);
        chk("distinct_vld", r_vld_b, 32'hFFFFFFDF);

        // reset mid-READY wipes contents
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_done", 32'(done_b), 32'h0);
        chk("rst2_vld", r_vld_b, 32'h0);
        chk("rst2_dout1", r_dout_b[1*DW +: DW], 32'h0);
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            chk("rst2_init_done", 32'(done_b), (k == DEPTH) ? 32'h1 : 32'h0);
        end
        read_all_zero("reclear");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
